// File: rtl/cprv_wb_unit.sv
// cprv_wb_unit: single-entry writeback buffer with load extraction, register file and instret counter.
// Optional same-cycle write-through on the read ports is enabled by defining CPRV_WB_BYPASS_EN.
module cprv_wb_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [4:0]            rd_addr_i,
    input  logic                  rd_en_i,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] alu_out_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  halt_i,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output logic                  commit_valid_o,
    output logic                  commit_we_o,
    output logic [4:0]            commit_rd_addr_o,
    output logic [DATA_WIDTH-1:0] commit_rd_data_o,
    output logic [63:0]           instret_o
);
    localparam int SH = $clog2(DATA_WIDTH / 8);

    logic                  full;
    logic                  b_en;
    logic [4:0]            b_rd;
    logic [6:0]            b_op;
    logic [2:0]            b_f3;
    logic [DATA_WIDTH-1:0] b_alu;
    logic [DATA_WIDTH-1:0] b_mem;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] lw;
    logic [DATA_WIDTH-1:0] ld;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  accept;

    assign ready_o          = !rst_n || !full || !halt_i;
    assign commit_valid_o   = rst_n && full && !halt_i;
    assign commit_we_o      = commit_valid_o && b_en && b_rd != 5'd0;
    assign accept           = rst_n && valid_i && ready_o;
    assign commit_rd_addr_o = b_rd;
    assign commit_rd_data_o = wdata;

    // Align the loaded word to the byte offset and extend it according to funct3.
    always_comb begin
        sh    = b_mem >> {b_alu[SH-1:0], 3'b000};
        lw    = DATA_WIDTH'($signed(sh[31:0]));
        ld    = (b_f3 == 3'd0) ? DATA_WIDTH'($signed(sh[7:0])) :
                (b_f3 == 3'd1) ? DATA_WIDTH'($signed(sh[15:0])) :
                (b_f3 == 3'd2) ? lw :
                (b_f3 == 3'd3) ? ((DATA_WIDTH == 64) ? sh : lw) :
                (b_f3 == 3'd4) ? DATA_WIDTH'(sh[7:0]) :
                (b_f3 == 3'd5) ? DATA_WIDTH'(sh[15:0]) :
                (b_f3 == 3'd6) ? DATA_WIDTH'(sh[31:0]) : '0;
        wdata = (b_op == 7'b0000011) ? ld : b_alu;
    end

    // Combinational register reads; x0 is hardwired to zero.
    always_comb begin
        rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs[rs2_addr_i];
`ifdef CPRV_WB_BYPASS_EN
        rs1_data_o = (commit_we_o && rs1_addr_i == b_rd) ? wdata : rs1_data_o;
        rs2_data_o = (commit_we_o && rs2_addr_i == b_rd) ? wdata : rs2_data_o;
`endif
    end

    // Buffer occupancy, payload capture and retired-instruction count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full      <= 1'b0;
            instret_o <= '0;
        end else begin
            if (accept) begin
                full  <= 1'b1;
                b_en  <= rd_en_i;
                b_rd  <= rd_addr_i;
                b_op  <= opcode_i;
                b_f3  <= funct3_i;
                b_alu <= alu_out_i;
                b_mem <= mem_data_i;
            end else if (commit_valid_o) begin
                full <= 1'b0;
            end
            if (commit_valid_o) instret_o <= instret_o + 64'd1;
        end
    end

    // Architectural register array, cleared on reset and written on commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (commit_we_o) begin
            regs[b_rd] <= wdata;
        end
    end
endmodule

// File: tb/tb_cprv_wb_unit.sv
// tb_cprv_wb_unit: scoreboard-driven bench for cprv_wb_unit at its default 64-bit configuration.
module tb_cprv_wb_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_en_i = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [63:0] alu_out_i = '0;
    logic [63:0] mem_data_i = '0;
    logic        halt_i = 1'b0;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic [63:0] rs1_data_o;
    logic [63:0] rs2_data_o;
    logic        commit_valid_o;
    logic        commit_we_o;
    logic [4:0]  commit_rd_addr_o;
    logic [63:0] commit_rd_data_o;
    logic [63:0] instret_o;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] mreg [32];
    logic [63:0] minst;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    cprv_wb_unit dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .alu_out_i(alu_out_i), .mem_data_i(mem_data_i), .halt_i(halt_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .commit_valid_o(commit_valid_o), .commit_we_o(commit_we_o),
        .commit_rd_addr_o(commit_rd_addr_o), .commit_rd_data_o(commit_rd_data_o),
        .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wb_model(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [63:0] alu, input logic [63:0] mem);
        logic [63:0] s;
        if (op != OP_LOAD) return alu;
        s = mem >> (alu[2:0] * 8);
        case (f3)
            3'd0: return {{56{s[7]}}, s[7:0]};
            3'd1: return {{48{s[15]}}, s[15:0]};
            3'd2: return {{32{s[31]}}, s[31:0]};
            3'd3: return s;
            3'd4: return {56'b0, s[7:0]};
            3'd5: return {48'b0, s[15:0]};
            3'd6: return {32'b0, s[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    // One cycle: drive inputs after the falling edge, score the commit, record any accept.
    task automatic drive(input logic v, input logic [4:0] rd, input logic en, input logic [6:0] op,
                         input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] mem,
                         input logic h);
        logic exp_full, exp_ready, exp_cv;
        exp_t e;
        valid_i = v; rd_addr_i = rd; rd_en_i = en; opcode_i = op;
        funct3_i = f3; alu_out_i = alu; mem_data_i = mem; halt_i = h;
        #1;
        exp_full  = sbq.size() != 0;
        exp_ready = !exp_full || !h;
        exp_cv    = exp_full && !h;
        vectors++;
        if (ready_o !== exp_ready) begin
            miscompares++;
            $display("FAIL ready: got %b want %b", ready_o, exp_ready);
        end
        vectors++;
        if (commit_valid_o !== exp_cv) begin
            miscompares++;
            $display("FAIL commit_valid: got %b want %b", commit_valid_o, exp_cv);
        end
        if (exp_cv) begin
            e = sbq.pop_front();
            vectors++;
            if (commit_we_o !== e.we || commit_rd_addr_o !== e.rd || (e.we && commit_rd_data_o !== e.data)) begin
                miscompares++;
                $display("FAIL commit: got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h",
                         commit_we_o, commit_rd_addr_o, commit_rd_data_o, e.we, e.rd, e.data);
            end
            if (e.we) mreg[e.rd] = e.data;
            minst++;
        end
        if (v && exp_ready) sbq.push_back('{we: en && rd != 5'd0, rd: rd, data: wb_model(op, f3, alu, mem)});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic h);
        drive(1'b0, 5'd0, 1'b0, 7'd0, 3'd0, 64'd0, 64'd0, h);
    endtask

    task automatic model_reset();
        sbq.delete();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        minst = '0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0; valid_i = 1'b1; rd_en_i = 1'b1; rd_addr_i = 5'd3; halt_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ready_o !== 1'b1 || commit_valid_o !== 1'b0 || commit_we_o !== 1'b0 || instret_o !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b cv=%b we=%b instret=%0d want 1 0 0 0",
                     ready_o, commit_valid_o, commit_we_o, instret_o);
        end
        rst_n = 1'b1;
        idle(1'b0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr_i = a[4:0]; rs2_addr_i = a[4:0]; #1;
            vectors++;
            if (rs1_data_o !== 64'd0 || rs2_data_o !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_reg x%0d: got %h/%h want 0", a, rs1_data_o, rs2_data_o);
            end
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3s  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [63:0] mem;
        drive(1'b1, 5'd5, 1'b1, OP_LOAD, 3'd0, 64'h2, 64'h0000_0000_0080_0000, 1'b0);
        drive(1'b1, 5'd6, 1'b1, OP_LOAD, 3'd4, 64'h2, 64'h0000_0000_0080_0000, 1'b0);
        idle(1'b0);
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd6; #1;
        vectors++;
        if (rs1_data_o !== 64'hFFFF_FFFF_FFFF_FF80 || rs2_data_o !== 64'h80) begin
            miscompares++;
            $display("FAIL lb_lbu: got %h/%h want ffffffffffffff80/80", rs1_data_o, rs2_data_o);
        end
        for (int i = 0; i < 8; i++) begin
            mem = {$urandom, $urandom} | 64'h8080_8080_8080_8080;
            drive(1'b1, 5'(10 + i), 1'b1, OP_LOAD, f3s[i], 64'($urandom_range(0, 7)), mem, 1'b0);
        end
        idle(1'b0);
        for (int i = 0; i < 8; i++) begin
            rs1_addr_i = 5'(10 + i); #1;
            vectors++;
            if (rs1_data_o !== mreg[10 + i]) begin
                miscompares++;
                $display("FAIL load_f3_%0d: got %h want %h", i, rs1_data_o, mreg[10 + i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] start;
        start = instret_o;
        drive(1'b1, 5'd1, 1'b1, OP_ALU, 3'd0, 64'd1, 64'd0, 1'b0);
        drive(1'b1, 5'd2, 1'b1, OP_ALU, 3'd0, 64'd2, 64'd0, 1'b0);
        drive(1'b1, 5'd3, 1'b1, OP_ALU, 3'd0, 64'd3, 64'd0, 1'b0);
        vectors++;
        if (instret_o !== start + 64'd2) begin
            miscompares++;
            $display("FAIL b2b_midway_instret: got %0d want %0d", instret_o, start + 64'd2);
        end
        idle(1'b0);
        vectors++;
        if (instret_o !== start + 64'd3) begin
            miscompares++;
            $display("FAIL b2b_instret: got %0d want %0d", instret_o, start + 64'd3);
        end
        for (int a = 1; a <= 3; a++) begin
            rs2_addr_i = a[4:0]; #1;
            vectors++;
            if (rs2_data_o !== 64'(a)) begin
                miscompares++;
                $display("FAIL b2b_x%0d: got %h want %h", a, rs2_data_o, 64'(a));
            end
        end
    endtask

    task automatic test_halt();
        logic [63:0] start;
        drive(1'b1, 5'd4, 1'b1, OP_ALU, 3'd0, 64'h44, 64'd0, 1'b0);
        start = instret_o;
        for (int i = 0; i < 4; i++) drive(1'b1, 5'd8, 1'b1, OP_ALU, 3'd0, 64'h88, 64'd0, 1'b1);
        vectors++;
        if (instret_o !== start) begin
            miscompares++;
            $display("FAIL halt_instret: got %0d want %0d", instret_o, start);
        end
        rs1_addr_i = 5'd4; #1;
        vectors++;
        if (rs1_data_o !== 64'd0) begin
            miscompares++;
            $display("FAIL halt_no_write: got %h want 0", rs1_data_o);
        end
        idle(1'b0);
        vectors++;
        if (instret_o !== start + 64'd1 || rs1_data_o !== 64'h44) begin
            miscompares++;
            $display("FAIL halt_release: got instret=%0d x4=%h want %0d 44", instret_o, rs1_data_o, start + 64'd1);
        end
        idle(1'b0);
    endtask

    task automatic test_x0();
        logic [63:0] start;
        start = instret_o;
        drive(1'b1, 5'd0, 1'b1, OP_ALU, 3'd0, 64'hDEAD, 64'd0, 1'b0);
        idle(1'b0);
        rs1_addr_i = 5'd0; #1;
        vectors++;
        if (rs1_data_o !== 64'd0 || instret_o !== start + 64'd1) begin
            miscompares++;
            $display("FAIL x0_write: got x0=%h instret=%0d want 0 %0d", rs1_data_o, instret_o, start + 64'd1);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] want;
        drive(1'b1, 5'd7, 1'b1, OP_ALU, 3'd0, 64'h1111, 64'd0, 1'b0);
        drive(1'b1, 5'd7, 1'b1, OP_ALU, 3'd0, 64'h1234, 64'd0, 1'b0);
        valid_i = 1'b0; halt_i = 1'b0; rs1_addr_i = 5'd7; #1;
`ifdef CPRV_WB_BYPASS_EN
        want = 64'h1234;
`else
        want = 64'h1111;
`endif
        vectors++;
        if (commit_we_o !== 1'b1 || rs1_data_o !== want) begin
            miscompares++;
            $display("FAIL bypass_commit_cycle: got we=%b x7=%h want 1 %h", commit_we_o, rs1_data_o, want);
        end
        idle(1'b0);
        vectors++;
        if (rs1_data_o !== 64'h1234) begin
            miscompares++;
            $display("FAIL bypass_next_cycle: got %h want 1234", rs1_data_o);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 5'd9, 1'b1, OP_ALU, 3'd0, 64'h99, 64'd0, 1'b0);
        rst_n = 1'b0; valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        rs1_addr_i = 5'd9; rs2_addr_i = 5'd1; #1;
        vectors++;
        if (ready_o !== 1'b1 || commit_valid_o !== 1'b0 || instret_o !== 64'd0 ||
            rs1_data_o !== 64'd0 || rs2_data_o !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_midflight: got ready=%b cv=%b instret=%0d x9=%h x1=%h want 1 0 0 0 0",
                     ready_o, commit_valid_o, instret_o, rs1_data_o, rs2_data_o);
        end
        idle(1'b0);
        drive(1'b1, 5'd9, 1'b1, OP_ALU, 3'd0, 64'h5A, 64'd0, 1'b0);
        idle(1'b0);
        #1;
        vectors++;
        if (rs1_data_o !== 64'h5A || instret_o !== 64'd1) begin
            miscompares++;
            $display("FAIL after_reset_op: got x9=%h instret=%0d want 5a 1", rs1_data_o, instret_o);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_halt();
        test_x0();
        test_bypass();
        test_reset_midflight();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cprv_wb_unit.md
CPRV_WB_UNIT -- requirements
Module: cprv_wb_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 64: register and datapath width; legal values 32 and 64 only.
REQ-002 Parameter REG_COUNT, default 32: number of architectural registers; x0 is included and reads as zero.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_i  in  1  upstream has an instruction for writeback.
- ready_o  out  1  unit accepts the instruction this cycle.
- rd_addr_i  in  5  destination register.
- rd_en_i  in  1  instruction writes rd.
- opcode_i  in  7  RISC-V opcode.
- funct3_i  in  3  load size/sign select.
- alu_out_i  in  DATA_WIDTH  ALU result or load address.
- mem_data_i  in  DATA_WIDTH  aligned memory word for loads.
- halt_i  in  1  hold commit (debug or stall).
- rs1_addr_i, rs2_addr_i  in  5 each  read addresses.
- rs1_data_o, rs2_data_o  out  DATA_WIDTH each  read data.
- commit_valid_o  out  1  buffered instruction commits this cycle.
- commit_we_o  out  1  commit writes a register (rd_en, rd!=0).
- commit_rd_addr_o  out  5  committing rd.
- commit_rd_data_o  out  DATA_WIDTH  committing write data.
- instret_o  out  64  retired-instruction count.

Function
REQ-004 Single-entry buffer; accept = valid_i && ready_o, capturing rd_addr, rd_en, opcode, funct3, alu_out and mem_data at that edge.
REQ-005 ready_o = !full || !halt_i; accept and commit in the same edge SHALL reload the buffer, sustaining 1 instruction per cycle.
REQ-006 commit_valid_o = full && !halt_i; at that edge the buffer empties unless a new accept occurs, instret_o increments by 1, and the register is written if commit_we_o.
REQ-007 Latency: an instruction accepted at edge N commits at edge N+1 when halt_i is low; the register value is visible at the rs ports from cycle N+2 without bypass.
REQ-008 commit_we_o = commit_valid_o && rd_en && rd_addr!=0; writes to x0 are dropped, and x0 always reads 0.
REQ-009 Write data for opcode 0000011 (LOAD): shift mem_data right by 8*alu_out[log2(DATA_WIDTH/8)-1:0], then extend:
- funct3 000 LB and 001 LH: sign-extend 8 and 16 bits.
- funct3 010 LW: sign-extend 32 bits.
- funct3 011 LD: full width; treated as LW when DATA_WIDTH=32.
- funct3 100 LBU and 101 LHU: zero-extend 8 and 16 bits.
- funct3 110 LWU: zero-extend 32 bits.
- funct3 111: result 0.
REQ-010 Any other opcode writes alu_out unchanged.
REQ-011 Register reads are combinational from the array.
REQ-012 While halt_i is high with the buffer full: ready_o=0 and the buffer holds.
REQ-013 With the buffer empty, ready_o=1 regardless of halt_i.
REQ-014 instret_o wraps from 2^64-1 to 0.
REQ-015 commit_rd_addr_o and commit_rd_data_o reflect the buffer contents whenever full, and are don't-care when empty.

Reset
REQ-016 While rst_n=0 at an edge: buffer empty, all registers 0, instret_o=0.
REQ-017 During reset: ready_o=1, commit_valid_o=0, commit_we_o=0.
REQ-018 Reset mid-operation SHALL discard the buffered instruction without committing it.
REQ-019 No input is accepted at an edge where rst_n=0.

Configuration
REQ-020 Macro CPRV_WB_BYPASS_EN defined: when commit_we_o is high and rsN_addr_i equals commit_rd_addr_o, rsN_data_o SHALL return commit_rd_data_o in that same cycle (write-through).
REQ-021 Macro CPRV_WB_BYPASS_EN undefined: rsN_data_o returns the array value only, so the pre-commit value is returned in the commit cycle.

Verification
REQ-022 LB load: DATA_WIDTH=64, mem_data=0x0000_0000_0080_0000, alu_out=0x...2 -> x5 written with 0xFFFF_FFFF_FFFF_FF80; same case with LBU -> 0x80.
REQ-023 Back-to-back ALU ops: ALU ops to x1 (value 1), x2 (value 2), x3 (value 3) presented on consecutive cycles -> ready_o stays 1, instret_o goes 0 to 3 in 3 cycles, and all 3 registers are written.
REQ-024 Halt hold: halt_i=1 for 4 cycles with the buffer full -> ready_o=0 and no commit; on release, a single commit occurs and instret_o increments by 1.
REQ-025 x0 write: ALU op with rd=0, alu_out=0xDEAD -> commit_we_o=0, rs1_addr=0 reads 0, and instret_o increments.
REQ-026 Bypass: rs1_addr=7 during the commit of x7=0x1234 -> with CPRV_WB_BYPASS_EN, 0x1234 in the same cycle; without it, the old value, then 0x1234 in the next cycle.
REQ-027 Reset mid-flight: rst_n=0 with the buffer full -> no register write occurs, and instret_o=0 and ready_o=1 after reset.
